// File: rtl/logic_unit_seq.sv
// ---------------------------------------------------------------------------
// logic_unit_seq
//   Sequential logic unit with valid/ready handshakes on both sides. It takes
//   one request at a time and returns one registered result. Bitwise ops and
//   rotate finish at the accept edge. Shifts move one bit per clock for
//   min(B, N) clocks.
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   in_valid    : request present on num1 / num2 / ALUControl
//   in_ready    : block is idle and can accept a request
//   num1        : operand A
//   num2        : operand B, also the shift amount for shift codes
//   ALUControl  : 000 OR, 001 XOR, 010 AND, 011 ROL1, 100 SRL, 101 SLL,
//                 110/111 unsupported
//   out_valid   : result and err are valid
//   out_ready   : consumer accepts the result
//   result      : registered result
//   err         : the accepted code was unsupported
// ---------------------------------------------------------------------------
module logic_unit_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] num1,
  input  logic [N-1:0] num2,
  input  logic [2:0]   ALUControl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         err
);

  // The counter must be able to hold N itself, not just N-1.
  localparam int            CW     = $clog2(N + 1);
  localparam logic [N-1:0]  N_AS_B = N'(N);
  localparam logic [CW-1:0] N_CNT  = CW'(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [N-1:0]  r_result;
  logic          r_err;
  logic [CW-1:0] r_cnt;
  logic          r_dir;       // 1: shift left, 0: shift right

  logic          w_accept;
  logic          w_is_shift;
  logic          w_unsup;
  logic [CW-1:0] w_k;
  logic [N-1:0]  w_load;

  assign w_accept   = in_valid && (r_state == IDLE);
  assign w_is_shift = (ALUControl == 3'b100) || (ALUControl == 3'b101);
  assign w_unsup    = ALUControl[2] & ALUControl[1];

  // Clamp over the full B width. This stops a large B from aliasing to a
  // small count once it is narrowed to CW bits.
  assign w_k = (num2 >= N_AS_B) ? N_CNT : num2[CW-1:0];

  // Value loaded into result at the accept edge. Shift codes start from A
  // and then shift in place.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    w_load = '0;
    unique case (ALUControl)
      3'b000:  w_load = num1 | num2;
      3'b001:  w_load = num1 ^ num2;
      3'b010:  w_load = num1 & num2;
      3'b011:  w_load = {num1[N-2:0], num1[N-1]};
      3'b100,
      3'b101:  w_load = num1;
      default: w_load = '0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = (w_is_shift && (w_k != '0)) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        // The count is never 0 in SHIFT. The edge that takes it from 1
        // finishes the op.
        if (r_cnt == CW'(1)) begin
          w_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath. Result and err only change at accept or during SHIFT, so they
  // hold through DONE and stay unchanged in IDLE until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_result <= w_load;
            r_err    <= w_unsup;
            r_cnt    <= w_is_shift ? w_k : '0;
            r_dir    <= ALUControl[0];
          end
        end
        SHIFT: begin
          r_result <= r_dir ? {r_result[N-2:0], 1'b0}
                            : {1'b0, r_result[N-1:1]};
          r_cnt    <= r_cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign err       = r_err;

endmodule

// File: tb/tb_logic_unit_seq.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_seq
//   Directed testbench for logic_unit_seq (N = 8). Each request pushes its
//   expected result, err and latency to a scoreboard queue. The entry is
//   popped and compared when out_valid rises. Latency counts clock edges
//   after the accept edge until out_valid is seen. Inputs are driven and
//   outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_logic_unit_seq;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] num1;
  logic [N-1:0] num2;
  logic [2:0]   ALUControl;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         err;

  always #5 clk = ~clk;

  logic_unit_seq #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .num1       (num1),
    .num2       (num2),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .err        (err)
  );

  typedef struct {
    logic [N-1:0] res;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for the random ops.
  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic [2:0] c, output logic [N-1:0] r,
                                output logic e, output int l);
    int k;
    k = (b >= N) ? N : int'(b);
    e = 1'b0;
    l = 0;
    case (c)
      3'd0: r = a | b;
      3'd1: r = a ^ b;
      3'd2: r = a & b;
      3'd3: r = {a[N-2:0], a[N-1]};
      3'd4: begin r = a >> k; l = k; end
      3'd5: begin r = a << k; l = k; end
      default: begin r = '0; e = 1'b1; end
    endcase
  endfunction

  // Runs one request. It is called while the DUT is in IDLE. With noise set,
  // in_valid and out_ready toggle to 1 where the DUT must ignore them.
  task automatic do_op(input string tag, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [2:0] code,
                       input logic [N-1:0] exp_res, input logic exp_err,
                       input int exp_lat, input int hold, input bit noise);
    exp_t e;
    int   lat;
    e.res = exp_res;
    e.err = exp_err;
    e.lat = exp_lat;
    sb.push_back(e);

    num1       = a;
    num2       = b;
    ALUControl = code;
    in_valid   = 1'b1;
    out_ready  = noise;
    check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Scramble the inputs after accept. The captured op must not change.
    in_valid   = noise;
    num1       = N'($urandom);
    num2       = N'($urandom);
    ALUControl = 3'($urandom);
    check({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);

    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    e = sb.pop_front();
    check({tag, " latency"}, 32'(lat), 32'(e.lat));
    check({tag, " result"}, 32'(result), 32'(e.res));
    check({tag, " err"}, 32'(err), 32'(e.err));

    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " hold result"}, 32'(result), 32'(e.res));
      check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
    end

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
    check({tag, " result held in IDLE"}, 32'(result), 32'(e.res));
    check({tag, " err held in IDLE"}, 32'(err), 32'(e.err));
  endtask

  initial begin
    logic [N-1:0] ra, rb, rr;
    logic [2:0]   rc;
    logic         re;
    int           rl;

    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    num1       = '0;
    num2       = '0;
    ALUControl = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset err", 32'(err), 32'd0);
    rst = 1'b0;

    // Bitwise, rotate and unsupported codes finish at the accept edge.
    do_op("or",    8'hC9, 8'hA7, 3'b000, 8'hEF, 1'b0, 0, 0, 1'b0);
    do_op("xor",   8'hC9, 8'hA7, 3'b001, 8'h6E, 1'b0, 0, 0, 1'b1);
    do_op("and",   8'hC9, 8'hA7, 3'b010, 8'h81, 1'b0, 0, 0, 1'b0);
    do_op("rol",   8'hC9, 8'hA7, 3'b011, 8'h93, 1'b0, 0, 0, 1'b1);
    do_op("op111", 8'hC9, 8'hA7, 3'b111, 8'h00, 1'b1, 0, 0, 1'b0);
    do_op("op110", 8'hC9, 8'hA7, 3'b110, 8'h00, 1'b1, 0, 0, 1'b1);

    // Shifts take min(B, N) cycles.
    do_op("srl4",   8'hC9, 8'd4,  3'b100, 8'h0C, 1'b0, 4, 0, 1'b1);
    do_op("sll4",   8'hC9, 8'd4,  3'b101, 8'h90, 1'b0, 4, 0, 1'b0);
    do_op("srl167", 8'hC9, 8'hA7, 3'b100, 8'h00, 1'b0, 8, 0, 1'b1);
    do_op("sll0",   8'hC9, 8'd0,  3'b101, 8'hC9, 1'b0, 0, 0, 1'b0);
    do_op("srl1",   8'hC9, 8'd1,  3'b100, 8'h64, 1'b0, 1, 0, 1'b0);
    do_op("sll8",   8'hFF, 8'd8,  3'b101, 8'h00, 1'b0, 8, 0, 1'b1);

    // Consumer stalls for 5 cycles. The next request follows back-to-back.
    do_op("stall", 8'h3C, 8'h0F, 3'b001, 8'h33, 1'b0, 0, 5, 1'b0);
    do_op("b2b",   8'h3C, 8'h0F, 3'b010, 8'h0C, 1'b0, 0, 0, 1'b0);

    // Reset asserted two cycles into a 6-cycle shift.
    num1       = 8'hC9;
    num2       = 8'd6;
    ALUControl = 3'b100;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("mid-shift out_valid", 32'(out_valid), 32'd0);
    check("mid-shift partial result", 32'(result), 32'h32);
    rst = 1'b1;
    #1;
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst result", 32'(result), 32'd0);
    check("async rst in_ready", 32'(in_ready), 32'd1);
    check("async rst err", 32'(err), 32'd0);
    #2;
    rst = 1'b0;
    do_op("post-rst or", 8'h12, 8'h40, 3'b000, 8'h52, 1'b0, 0, 0, 1'b0);

    // Random ops checked against the reference model.
    for (int i = 0; i < 16; i++) begin
      ra = N'($urandom);
      rc = 3'($urandom_range(0, 7));
      rb = ($urandom_range(0, 1) == 0) ? N'($urandom_range(0, 10)) : N'($urandom);
      model(ra, rb, rc, rr, re, rl);
      do_op($sformatf("rand%0d", i), ra, rb, rc, rr, re, rl,
            int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
